counter_cmd_sequencer: RTL and testbench

// - Sequences a 4-bit up/down counter from a queue of commands (LOAD / COUNT UP n / COUNT DOWN n / NOP).
// - Drives the counter's load, up_down, enable and d_in pins; observes its count output.
// - Signals command completion and counter wrap events.
// - Sits between a command master (valid/ready) and one counter instance.

---
 rtl/counter_cmd_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_counter_cmd_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_cmd_sequencer.sv
// Command-queue sequencer driving one up/down counter (LOAD / UP n / DOWN n / NOP).
// Optional SEQ_SATURATE_EN: runs stop instead of wrapping, flagged by sat_hit.
module counter_cmd_sequencer #(
    parameter int CNT_W      = 4,
    parameter int STEP_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [CNT_W-1:0]  cmd_arg,
    input  logic [STEP_W-1:0] cmd_steps,
    input  logic [CNT_W-1:0]  cnt_value,
    output logic              cnt_load,
    output logic [CNT_W-1:0]  cnt_d_in,
    output logic              cnt_up_down,
    output logic              cnt_enable,
    output logic              busy,
    output logic              done,
    output logic              wrap_evt,
    output logic              sat_hit
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = 2 + CNT_W + STEP_W;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_UP   = 2'b10;
    localparam logic [1:0] OP_DOWN = 2'b11;

`ifdef SEQ_SATURATE_EN
    localparam logic SAT_ON = 1'b1;
`else
    localparam logic SAT_ON = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_t;

    logic [DW-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;

    logic [1:0]        head_op;
    logic [CNT_W-1:0]  head_arg;
    logic [STEP_W-1:0] head_steps;

    state_t            state_q, state_d;
    logic [1:0]        op_q, op_d;
    logic [CNT_W-1:0]  arg_q, arg_d;
    logic [STEP_W-1:0] rem_q, rem_d;
    logic              ud_q, ud_d;
    logic              sat_q, sat_d;

    logic             load_w;
    logic [CNT_W-1:0] din_w;
    logic             en_w;
    logic             will_wrap;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push  = cmd_valid && !full;
    assign pop   = (state_q == S_IDLE) && !empty;

    assign {head_op, head_arg, head_steps} = mem_q[rd_ptr_q[AW-1:0]];

    assign wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {cmd_op, cmd_arg, cmd_steps};
        end
    end

    // Pre-edge count tells whether the step about to be taken wraps.
    assign will_wrap = ud_q ? (cnt_value == {CNT_W{1'b1}})
                            : (cnt_value == {CNT_W{1'b0}});

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        arg_d   = arg_q;
        rem_d   = rem_q;
        ud_d    = ud_q;
        sat_d   = sat_q;
        load_w  = 1'b0;
        din_w   = '0;
        en_w    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    op_d    = head_op;
                    arg_d   = head_arg;
                    rem_d   = head_steps;
                    sat_d   = 1'b0;
                    state_d = S_EXEC;
                    if (head_op[1]) begin
                        ud_d = ~head_op[0];
                    end
                end
            end
            S_EXEC: begin
                unique case (op_q)
                    OP_LOAD: begin
                        load_w  = 1'b1;
                        din_w   = arg_q;
                        state_d = S_DONE;
                    end
                    OP_NOP: begin
                        state_d = S_DONE;
                    end
                    OP_UP, OP_DOWN: begin
                        if (rem_q == '0) begin
                            state_d = S_DONE;
                        end else if (SAT_ON && will_wrap) begin
                            sat_d   = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            en_w  = 1'b1;
                            rem_d = rem_q - 1'b1;
                            if (rem_q == STEP_W'(1)) begin
                                state_d = S_DONE;
                            end
                        end
                    end
                endcase
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            op_q     <= OP_NOP;
            arg_q    <= '0;
            rem_q    <= '0;
            ud_q     <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            op_q     <= op_d;
            arg_q    <= arg_d;
            rem_q    <= rem_d;
            ud_q     <= ud_d;
            sat_q    <= sat_d;
        end
    end

    assign cmd_ready   = !full;
    assign cnt_load    = load_w;
    assign cnt_d_in    = din_w;
    assign cnt_enable  = en_w;
    assign cnt_up_down = ud_q;
    assign busy        = (state_q != S_IDLE) || !empty;
    assign done        = (state_q == S_DONE);

`ifdef SEQ_SATURATE_EN
    assign wrap_evt = 1'b0;
    assign sat_hit  = (state_q == S_DONE) && sat_q;
`else
    assign wrap_evt = en_w && will_wrap;
    assign sat_hit  = 1'b0;
`endif

endmodule

// File: tb/tb_counter_cmd_sequencer.sv
// Bench for counter_cmd_sequencer: behavioural counter, command table,
// per-command scoreboard checked at each done pulse.
module tb_counter_cmd_sequencer;

    typedef struct {
        logic [1:0] op;
        logic [3:0] arg;
        logic [7:0] steps;
        logic [3:0] cnt;
        int         en;
        int         ld;
        int         wr;
        logic       sat;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_arg;
    logic [7:0] cmd_steps;
    logic [3:0] cnt = 4'd0;
    logic       cnt_load;
    logic [3:0] cnt_d_in;
    logic       cnt_up_down;
    logic       cnt_enable;
    logic       busy;
    logic       done;
    logic       wrap_evt;
    logic       sat_hit;

    int   checks = 0;
    int   errors = 0;
    int   n_done = 0;
    vec_t exp_q[$];
    vec_t tbl[8];

    counter_cmd_sequencer #(
        .CNT_W(4), .STEP_W(8), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cmd_steps(cmd_steps),
        .cnt_value(cnt), .cnt_load(cnt_load), .cnt_d_in(cnt_d_in),
        .cnt_up_down(cnt_up_down), .cnt_enable(cnt_enable),
        .busy(busy), .done(done), .wrap_evt(wrap_evt), .sat_hit(sat_hit)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cnt_load)
            cnt <= cnt_d_in;
        else if (cnt_enable)
            cnt <= cnt_up_down ? cnt + 4'd1 : cnt - 4'd1;
    end

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] op, input logic [3:0] arg,
                                input logic [7:0] steps, input logic [3:0] c,
                                input int en, input int ld, input int wr,
                                input logic sat);
        vec_t v;
        v.op = op; v.arg = arg; v.steps = steps; v.cnt = c;
        v.en = en; v.ld = ld; v.wr = wr; v.sat = sat;
        return v;
    endfunction

    // Per-command tallies, compared against the scoreboard head at done.
    initial begin : monitor
        int n_en, n_ld, n_wr;
        vec_t e;
        n_en = 0; n_ld = 0; n_wr = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                n_en = 0; n_ld = 0; n_wr = 0;
            end else begin
                chk("load_and_enable", int'(cnt_load && cnt_enable), 0);
                if (!cnt_load) chk("d_in_idle", int'(cnt_d_in), 0);
                if (!done) chk("sat_without_done", int'(sat_hit), 0);
                n_en += int'(cnt_enable);
                n_ld += int'(cnt_load);
                n_wr += int'(wrap_evt);
                if (done) begin
                    n_done++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_done", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("count", int'(cnt), int'(e.cnt));
                        chk("enables", n_en, e.en);
                        chk("loads", n_ld, e.ld);
                        chk("wraps", n_wr, e.wr);
                        chk("sat_hit", int'(sat_hit), int'(e.sat));
                    end
                    n_en = 0; n_ld = 0; n_wr = 0;
                end
            end
        end
    end

    task automatic send(input vec_t v);
        int n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            chk("ready_timeout", 0, 1);
        end else begin
            cmd_op = v.op; cmd_arg = v.arg; cmd_steps = v.steps;
            cmd_valid = 1'b1;
            exp_q.push_back(v);
            @(posedge clk);
            #1 cmd_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", int'(busy), 0);
    endtask

    initial begin
        int n;
        int d0;
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_arg = 4'd0; cmd_steps = 8'd0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_enable", int'(cnt_enable), 0);
        chk("rst_up_down", int'(cnt_up_down), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", int'(cmd_ready), 1);

        // First LOAD: load strobe two cycles after acceptance, done one later.
        cmd_op = 2'b01; cmd_arg = 4'd5; cmd_steps = 8'd0; cmd_valid = 1'b1;
        exp_q.push_back(mk(2'b01, 4'd5, 8'd0, 4'd5, 0, 1, 0, 1'b0));
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        chk("lat_busy", int'(busy), 1);
        chk("lat_load_early", int'(cnt_load), 0);
        @(negedge clk);
        chk("lat_load", int'(cnt_load), 1);
        chk("lat_d_in", int'(cnt_d_in), 5);
        @(negedge clk);
        chk("lat_done", int'(done), 1);
        wait_idle();

        tbl[0] = mk(2'b10, 4'd0, 8'd3, 4'd8, 3, 0, 0, 1'b0);
        tbl[1] = mk(2'b01, 4'd1, 8'd0, 4'd1, 0, 1, 0, 1'b0);
`ifdef SEQ_SATURATE_EN
        tbl[2] = mk(2'b11, 4'd0, 8'd3, 4'd0, 1, 0, 0, 1'b1);
        tbl[3] = mk(2'b10, 4'd0, 8'd0, 4'd0, 0, 0, 0, 1'b0);
        tbl[4] = mk(2'b00, 4'd7, 8'd9, 4'd0, 0, 0, 0, 1'b0);
        tbl[5] = mk(2'b01, 4'd14, 8'd0, 4'd14, 0, 1, 0, 1'b0);
        tbl[6] = mk(2'b10, 4'd0, 8'd3, 4'd15, 1, 0, 0, 1'b1);
        tbl[7] = mk(2'b11, 4'd0, 8'd2, 4'd13, 2, 0, 0, 1'b0);
`else
        tbl[2] = mk(2'b11, 4'd0, 8'd3, 4'd14, 3, 0, 1, 1'b0);
        tbl[3] = mk(2'b10, 4'd0, 8'd0, 4'd14, 0, 0, 0, 1'b0);
        tbl[4] = mk(2'b00, 4'd7, 8'd9, 4'd14, 0, 0, 0, 1'b0);
        tbl[5] = mk(2'b01, 4'd14, 8'd0, 4'd14, 0, 1, 0, 1'b0);
        tbl[6] = mk(2'b10, 4'd0, 8'd3, 4'd1, 3, 0, 1, 1'b0);
        tbl[7] = mk(2'b11, 4'd0, 8'd2, 4'd15, 2, 0, 1, 1'b0);
`endif
        for (int i = 0; i < 8; i++) begin
            send(tbl[i]);
            wait_idle();
        end

        // Fill the queue behind a long run; the fifth push must stall.
        send(mk(2'b01, 4'd0, 8'd0, 4'd0, 0, 1, 0, 1'b0));
`ifdef SEQ_SATURATE_EN
        send(mk(2'b10, 4'd0, 8'd20, 4'd15, 15, 0, 0, 1'b1));
`else
        send(mk(2'b10, 4'd0, 8'd20, 4'd4, 20, 0, 1, 1'b0));
`endif
        n = 0;
        while (!cnt_enable && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("run_started", int'(cnt_enable), 1);
        for (int i = 1; i <= 4; i++)
            send(mk(2'b01, 4'(i), 8'd0, 4'(i), 0, 1, 0, 1'b0));
        chk("full_ready", int'(cmd_ready), 0);
        send(mk(2'b01, 4'd5, 8'd0, 4'd5, 0, 1, 0, 1'b0));
        wait_idle();
        chk("queue_drained", exp_q.size(), 0);

        // Asynchronous reset in the middle of a long run.
        send(mk(2'b01, 4'd0, 8'd0, 4'd0, 0, 1, 0, 1'b0));
        send(mk(2'b10, 4'd0, 8'd200, 4'd0, 200, 0, 0, 1'b0));
        n = 0;
        while (!cnt_enable && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("long_run_started", int'(cnt_enable), 1);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_enable", int'(cnt_enable), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_up_down", int'(cnt_up_down), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_ready", int'(cmd_ready), 1);
        exp_q.delete();
        d0 = n_done;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        chk("post_rst_dones", n_done, d0);
        chk("post_rst_busy", int'(busy), 0);
        chk("post_rst_enable", int'(cnt_enable), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
